// File: rtl/axis_deadlock_monitor_p_if.sv
// Observation bundle for axis_deadlock_monitor_p: the stall/idle/child flags it watches and
// the detection outputs it reports. The harness side takes the master modport and the
// monitor takes the slave modport.
// AXIS_DEADLOCK_TIMESTAMP_EN adds block_time to the bundle.
interface axis_deadlock_monitor_p_if #(
  parameter int unsigned N_CHAN = 8,
  parameter int unsigned N_INST = 5,
  parameter int unsigned N_SUB  = 2
);
  logic [N_CHAN-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_SUB-1:0]  sub_block_in;
  logic              block;
  logic [N_CHAN-1:0] block_chan;
  logic              block_event;
`ifdef AXIS_DEADLOCK_TIMESTAMP_EN
  logic [31:0]       block_time;

  modport master (
    output axis_block_sigs, inst_idle_sigs, sub_block_in,
    input  block, block_chan, block_event, block_time
  );
  modport slave (
    input  axis_block_sigs, inst_idle_sigs, sub_block_in,
    output block, block_chan, block_event, block_time
  );
`else
  modport master (
    output axis_block_sigs, inst_idle_sigs, sub_block_in,
    input  block, block_chan, block_event
  );
  modport slave (
    input  axis_block_sigs, inst_idle_sigs, sub_block_in,
    output block, block_chan, block_event
  );
`endif
endinterface

// File: rtl/axis_deadlock_monitor_p.sv
// Hierarchical AXI-Stream deadlock monitor. It combines the channels this level owns with
// the channels of the children that currently report a block. A qualifying condition must
// persist HOLD_CYCLES cycles before block asserts. When block asserts, the module captures
// which channels were stalled.
// Optional macro AXIS_DEADLOCK_TIMESTAMP_EN adds a free-running cycle counter. That counter
// is latched into block_time on each detection.
module axis_deadlock_monitor_p #(
  parameter int unsigned              N_CHAN        = 8,
  parameter int unsigned              N_INST        = 5,
  parameter int unsigned              N_SUB         = 2,
  parameter logic [N_CHAN-1:0]        LOCAL_MASK    = 8'h03,
  parameter logic [N_SUB*N_CHAN-1:0]  SUB_CHAN_MASK = 16'hF0_0C,
  parameter int unsigned              HOLD_CYCLES   = 1,
  parameter int unsigned              STICKY        = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  axis_deadlock_monitor_p_if.slave mon
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enter_c;
  logic [N_CHAN-1:0] sel_mask_c;
  logic [N_CHAN-1:0] hit_vec_c;
  logic              all_idle_c;
  logic              cond_c;
  logic              block_q;
  logic [N_CHAN-1:0] block_chan_q;
  logic              block_event_q;

  // Eligible channels: local ones, plus every child slice whose child is blocking. Any
  // local or gated sub hit is then simply a set bit of hit_vec.
  always_comb begin
    sel_mask_c = LOCAL_MASK;
    for (int i = 0; i < int'(N_SUB); i++) begin
      if (mon.sub_block_in[i]) begin
        sel_mask_c = sel_mask_c | SUB_CHAN_MASK[i*N_CHAN +: N_CHAN];
      end
    end
    hit_vec_c  = mon.axis_block_sigs & sel_mask_c;
    all_idle_c = &mon.inst_idle_sigs;
    cond_c     = (|hit_vec_c) & ~all_idle_c;
  end

  // Next-state logic. Clear overrides the condition and restarts the hold window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter_c = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cond_c) begin
            if (HOLD_CYCLES == 1) begin
              state_d = BLOCKED;
              enter_c = 1'b1;
            end else begin
              state_d = SUSPECT;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        SUSPECT: begin
          if (!cond_c) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = BLOCKED;
            enter_c = 1'b1;
          end else if (cnt_q != CNT_W'(HOLD_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BLOCKED: begin
          if ((STICKY == 0) && !cond_c) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs. block mirrors the BLOCKED state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      block_q       <= 1'b0;
      block_chan_q  <= '0;
      block_event_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      block_q       <= (state_d == BLOCKED);
      block_event_q <= enter_c;
      if (clear) begin
        block_chan_q <= '0;
      end else if (enter_c) begin
        block_chan_q <= hit_vec_c;
      end
    end
  end

  assign mon.block       = block_q;
  assign mon.block_chan  = block_chan_q;
  assign mon.block_event = block_event_q;

`ifdef AXIS_DEADLOCK_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] block_time_q;

  // Free-running cycle counter. Its value is latched when the monitor enters BLOCKED.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_q      <= '0;
      block_time_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (clear) begin
        block_time_q <= '0;
      end else if (enter_c) begin
        block_time_q <= cycle_q;
      end
    end
  end

  assign mon.block_time = block_time_q;
`endif

endmodule

// File: tb/tb_axis_deadlock_monitor_p.sv
// Bench for axis_deadlock_monitor_p. Three instances share one stimulus stream:
// HOLD=1 non-sticky, HOLD=4 non-sticky, and HOLD=2 sticky. A directed table, hand
// sequences and a randomized run are all compared against a run-length reference model.
module tb_axis_deadlock_monitor_p;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] axis  = '0;
  logic [4:0] idle  = '0;
  logic [1:0] sub   = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  axis_deadlock_monitor_p_if #(.N_CHAN(8), .N_INST(5), .N_SUB(2)) if0 ();
  axis_deadlock_monitor_p_if #(.N_CHAN(8), .N_INST(5), .N_SUB(2)) if1 ();
  axis_deadlock_monitor_p_if #(.N_CHAN(8), .N_INST(5), .N_SUB(2)) if2 ();

  assign if0.axis_block_sigs = axis;
  assign if0.inst_idle_sigs  = idle;
  assign if0.sub_block_in    = sub;
  assign if1.axis_block_sigs = axis;
  assign if1.inst_idle_sigs  = idle;
  assign if1.sub_block_in    = sub;
  assign if2.axis_block_sigs = axis;
  assign if2.inst_idle_sigs  = idle;
  assign if2.sub_block_in    = sub;

  axis_deadlock_monitor_p #(.HOLD_CYCLES(1), .STICKY(0)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .mon(if0));
  axis_deadlock_monitor_p #(.HOLD_CYCLES(4), .STICKY(0)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .mon(if1));
  axis_deadlock_monitor_p #(.HOLD_CYCLES(2), .STICKY(1)) dut2 (
    .clock(clock), .reset(reset), .clear(clear), .mon(if2));

  logic       blk_d [3];
  logic [7:0] chan_d[3];
  logic       evt_d [3];
  assign blk_d[0] = if0.block;  assign chan_d[0] = if0.block_chan;  assign evt_d[0] = if0.block_event;
  assign blk_d[1] = if1.block;  assign chan_d[1] = if1.block_chan;  assign evt_d[1] = if1.block_event;
  assign blk_d[2] = if2.block;  assign chan_d[2] = if2.block_chan;  assign evt_d[2] = if2.block_event;

  // Reference model: count consecutive qualifying cycles; block once the count reaches HOLD.
  localparam logic [7:0]  M_LOCAL = 8'h03;
  localparam logic [15:0] M_SUB   = 16'hF00C;
  int         hold_m  [3] = '{1, 4, 2};
  bit         sticky_m[3] = '{0, 0, 1};
  int         run_m   [3];
  logic       blk_m   [3];
  logic [7:0] chan_m  [3];
  logic       evt_m   [3];
  logic [31:0] ts_m = '0;
  logic [31:0] bt_m = '0;

  // Builds the hit vector bit by bit. A channel counts when it is stalled and either owned
  // locally or owned by a child that is currently blocking.
  function automatic logic [7:0] ref_hits(input logic [7:0] a, input logic [1:0] s);
    logic [7:0]  r;
    logic [15:0] m;
    r = '0;
    m = M_SUB;
    for (int c = 0; c < 8; c++) begin
      bit owned;
      owned = M_LOCAL[c];
      for (int i = 0; i < 2; i++) if (s[i] && m[i*8 + c]) owned = 1'b1;
      if (a[c] && owned) r[c] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step();
    logic [7:0] hv;
    bit cond, nb;
    hv = ref_hits(axis, sub);
    cond = (hv != 8'h00) && (idle != 5'h1F);
    for (int k = 0; k < 3; k++) begin
      if (!reset || clear) begin
        run_m[k] = 0; blk_m[k] = 0; chan_m[k] = '0; evt_m[k] = 0;
      end else begin
        run_m[k] = cond ? ((run_m[k] < 1000) ? run_m[k] + 1 : run_m[k]) : 0;
        nb = (run_m[k] >= hold_m[k]) || (sticky_m[k] && blk_m[k]);
        evt_m[k] = nb && !blk_m[k];
        if (evt_m[k]) chan_m[k] = hv;
        blk_m[k] = nb;
      end
    end
    if (!reset) begin
      ts_m = '0; bt_m = '0;
    end else begin
      if (clear) bt_m = '0;
      else if (evt_m[0]) bt_m = ts_m;
      ts_m = ts_m + 32'd1;
    end
  endtask

  // Advances one clock: the model sees the same inputs the DUTs sample, and checks happen on the falling edge.
  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] axis;
    logic [4:0] idle;
    logic [1:0] sub;
    logic       clr;
    logic       e_blk;
    logic [7:0] e_chan;
    logic       e_evt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int hold_left;
    for (int k = 0; k < 3; k++) begin
      run_m[k] = 0; blk_m[k] = 0; chan_m[k] = '0; evt_m[k] = 0;
    end
    @(negedge clock);
    repeat (2) cycle();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_blk%0d", k),  32'(blk_d[k]),  32'd0);
      chk($sformatf("reset_chan%0d", k), 32'(chan_d[k]), 32'd0);
      chk($sformatf("reset_evt%0d", k),  32'(evt_d[k]),  32'd0);
    end
    reset = 1'b1;

    // Directed table for the HOLD=1 instance; each row sets the outputs after one edge.
    vecs[0]  = '{8'h01, 5'h00, 2'b00, 1'b0, 1'b1, 8'h01, 1'b1};
    vecs[1]  = '{8'h01, 5'h00, 2'b00, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[2]  = '{8'h00, 5'h00, 2'b00, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[3]  = '{8'h04, 5'h00, 2'b01, 1'b0, 1'b1, 8'h04, 1'b1};
    vecs[4]  = '{8'h10, 5'h00, 2'b01, 1'b0, 1'b0, 8'h04, 1'b0};
    vecs[5]  = '{8'h10, 5'h00, 2'b10, 1'b0, 1'b1, 8'h10, 1'b1};
    vecs[6]  = '{8'hFF, 5'h1F, 2'b11, 1'b0, 1'b0, 8'h10, 1'b0};
    vecs[7]  = '{8'hFF, 5'h1E, 2'b00, 1'b0, 1'b1, 8'h03, 1'b1};
    vecs[8]  = '{8'h07, 5'h00, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{8'h0F, 5'h00, 2'b01, 1'b0, 1'b1, 8'h0F, 1'b1};
    vecs[10] = '{8'h00, 5'h00, 2'b00, 1'b0, 1'b0, 8'h0F, 1'b0};
    for (int i = 0; i < 11; i++) begin
      axis = vecs[i].axis; idle = vecs[i].idle; sub = vecs[i].sub; clear = vecs[i].clr;
      cycle();
      chk($sformatf("vec%0d_blk", i),  32'(if0.block),       32'(vecs[i].e_blk));
      chk($sformatf("vec%0d_chan", i), 32'(if0.block_chan),  32'(vecs[i].e_chan));
      chk($sformatf("vec%0d_evt", i),  32'(if0.block_event), 32'(vecs[i].e_evt));
    end
    clear = 1'b0; axis = '0; idle = '0; sub = '0;
    cycle();

    // HOLD=4: three stalled cycles are not enough; four are.
    axis = 8'h02;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("h4_short%0d", i), 32'(if1.block), 32'd0);
    end
    axis = 8'h00; cycle();
    chk("h4_gap", 32'(if1.block), 32'd0);
    axis = 8'h02;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("h4_wait%0d", i), 32'(if1.block), 32'd0);
    end
    cycle();
    chk("h4_blk", 32'(if1.block), 32'd1);
    chk("h4_evt", 32'(if1.block_event), 32'd1);
    chk("h4_chan", 32'(if1.block_chan), 32'h02);
    axis = 8'h00; cycle();

    // Reset in the middle of SUSPECT restarts the full hold window.
    axis = 8'h02;
    repeat (2) cycle();
    reset = 1'b0; cycle();
    chk("rst_mid_blk",  32'(if1.block), 32'd0);
    chk("rst_mid_chan", 32'(if1.block_chan), 32'd0);
    chk("rst_mid_evt",  32'(if1.block_event), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("rst_rearm%0d", i), 32'(if1.block), 32'd0);
    end
    cycle();
    chk("rst_rearm_blk", 32'(if1.block), 32'd1);
    axis = 8'h00; cycle();

    // Sticky instance with HOLD=2.
    clear = 1'b1; cycle(); clear = 1'b0;
    axis = 8'h01; cycle();
    chk("st_wait", 32'(if2.block), 32'd0);
    cycle();
    chk("st_blk", 32'(if2.block), 32'd1);
    chk("st_evt", 32'(if2.block_event), 32'd1);
    chk("st_chan", 32'(if2.block_chan), 32'h01);
    axis = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("st_hold%0d", i), 32'(if2.block), 32'd1);
    end
    axis = 8'h01; clear = 1'b1; cycle(); clear = 1'b0;
    chk("st_clr_blk", 32'(if2.block), 32'd0);
    chk("st_clr_chan", 32'(if2.block_chan), 32'd0);
    cycle();
    chk("st_fresh_wait", 32'(if2.block), 32'd0);
    cycle();
    chk("st_fresh_blk", 32'(if2.block), 32'd1);
    axis = 8'h00; clear = 1'b1; cycle(); clear = 1'b0;
    chk("st_clr2_blk", 32'(if2.block), 32'd0);

`ifdef AXIS_DEADLOCK_TIMESTAMP_EN
    // The detection edge 101 edges after the reset edge latches 100.
    reset = 1'b0; cycle(); reset = 1'b1;
    axis = 8'h00;
    repeat (100) cycle();
    axis = 8'h01; cycle();
    chk("ts_blk", 32'(if0.block), 32'd1);
    chk("ts_time", if0.block_time, 32'd100);
    axis = 8'h00; cycle();
`endif

    // Randomized run: inputs are held for several cycles so that long holds can complete.
    hold_left = 0;
    for (int n = 0; n < 600; n++) begin
      if (hold_left == 0) begin
        hold_left = int'($urandom_range(1, 7));
        axis = 8'($urandom) & 8'($urandom);
        sub  = 2'($urandom);
        idle = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
      end
      hold_left--;
      clear = ($urandom_range(0, 23) == 0);
      reset = ($urandom_range(0, 79) != 0);
      cycle();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd%0d_blk%0d", n, k),  32'(blk_d[k]),  32'(blk_m[k]));
        chk($sformatf("rnd%0d_chan%0d", n, k), 32'(chan_d[k]), 32'(chan_m[k]));
        chk($sformatf("rnd%0d_evt%0d", n, k),  32'(evt_d[k]),  32'(evt_m[k]));
      end
`ifdef AXIS_DEADLOCK_TIMESTAMP_EN
      chk($sformatf("rnd%0d_time", n), if0.block_time, bt_m);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
